// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives word addresses to the
// combinational instruction memory, and captures the IF/ID pipeline register.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned NMEM     = 128,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] im_addr_o,
    input  logic [31:0] im_data_i,
    output logic        id_valid_o,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_instr_o,
    output logic        id_fault_o
);

    localparam int unsigned XLEN = 32;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            fault;
    } ifid_t;

    localparam ifid_t IFID_BUBBLE = '{valid: 1'b0, pc: '0, instr: NOP, fault: 1'b0};

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    ifid_t           ifid_q;
    ifid_t           ifid_d;
    logic            fetch_fault_c;

    // Word index excludes the byte offset; misaligned PCs are caught as faults.
    assign im_addr_o     = {2'b00, pc_q[31:2]};
    assign fetch_fault_c = (pc_q[1:0] != 2'b00) || (im_addr_o >= XLEN'(NMEM));

    // Next PC: redirect beats stall beats sequential advance (wraps mod 2^32).
    always_comb begin
        pc_d = pc_q;
        if (redirect_i) begin
            pc_d = redirect_pc_i;
        end else if (!stall_i) begin
            pc_d = pc_q + XLEN'(4);
        end
    end

    // Next IF/ID: a flush still squashes a stalled slot.
    always_comb begin
        ifid_d = ifid_q;
        if (redirect_i || flush_i) begin
            ifid_d = IFID_BUBBLE;
        end else if (!stall_i) begin
            ifid_d.valid = 1'b1;
            ifid_d.pc    = pc_q;
            ifid_d.fault = fetch_fault_c;
            ifid_d.instr = fetch_fault_c ? NOP : im_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q   <= RESET_PC;
            ifid_q <= IFID_BUBBLE;
        end else begin
            pc_q   <= pc_d;
            ifid_q <= ifid_d;
        end
    end

    assign id_valid_o = ifid_q.valid;
    assign id_pc_o    = ifid_q.pc;
    assign id_instr_o = ifid_q.instr;
    assign id_fault_o = ifid_q.fault;

endmodule
